mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the 5-stage MIPS pipeline.
- Sits beside the ALU in the E stage and owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from E and sequences the fixed-latency operation.
- Raises a stall request to the hazard unit while a D-stage instruction would touch HI/LO too early.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_LAT, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  E-stage instruction is an MD op this cycle; qualifies md_op
- md_op  in  3  001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; others are no-ops
- rs_val  in  32  forwarded rs operand from the E stage
- rt_val  in  32  forwarded rt operand from the E stage
- md_use_D  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- busy  out  1  multi-cycle operation in progress
- hi  out  32  HI register
- lo  out  32  LO register
- md_stall  out  1  stall request to the hazard unit (OR'd into stall/Flush_E)

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, busy 0, hi 0, lo 0, operand/result latches 0.
- md_stall is combinational: md_stall = md_use_D & (busy | (start & md_op in {001..100})).
- FSM has two states, IDLE and BUSY.
- IDLE:
  - start with op 001..100 (edge at cycle t): latch operands and op, load counter with LAT for that op, go to BUSY. busy is 1 from cycle t+1.
  - start with 101: hi <= rs_val at that edge. No busy.
  - start with 110: lo <= rs_val at that edge. No busy.
  - start with any other op: no effect.
- BUSY:
  - Counter decrements each edge.
  - At the edge where counter goes 1->0: write hi/lo from the result, return to IDLE, busy drops.
  - busy is therefore high for exactly LAT cycles (t+1..t+LAT). New hi/lo values are visible in cycle t+LAT+1, the same cycle busy is low.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
  - multu: the same operation, unsigned.
  - div: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero: hi/lo are left unchanged; busy still runs the full DIV_LAT.
  - Overflow case 0x80000000 / 0xFFFFFFFF (div): lo = 0x80000000, hi = 0.
  - Results are computed from the latched operands. Operand changes during BUSY have no effect.
- start while BUSY: ignored, including mthi/mtlo. The hazard unit guarantees this cannot happen; the bench asserts on it.
- Reset asserted mid-operation: immediate return to IDLE, busy 0, hi/lo 0. The pending result is discarded.
- start in the same cycle busy falls (state already IDLE): accepted normally. Back-to-back operations incur no bubble.

Test Plan:
1. Reset, start mult rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. multu rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
3. div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu rs=7, rt=0 -> busy 10 cycles, hi/lo unchanged.
4. mthi rs=0x1234 then mtlo rs=0x5678 on consecutive cycles -> hi=0x1234 and lo=0x5678 one edge each after start; busy never asserts.
5. div issued; md_use_D=1 during the start cycle and all busy cycles -> md_stall=1 in each of those 11 cycles and 0 the cycle busy falls. With md_use_D=0, md_stall stays 0.
6. Start div, deassert rst_n in the 4th busy cycle -> busy, hi and lo go to 0 immediately. A mult started after reset release completes normally.

Source files
------------

// File: rtl/mdu_if.sv
// Handshake and result bundle between the E-stage issue logic and the
// multiply/divide controller.
interface mdu_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_stall;

    modport master (
        output start, md_op, rs_val, rt_val, md_use_D,
        input  busy, hi, lo, md_stall
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, md_use_D,
        output busy, hi, lo, md_stall
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning HI/LO. Operands are latched
// at issue; the result is committed when the fixed-latency countdown expires.
module mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave md
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic [2:0]         op_p0, op_nxt;
    logic signed [31:0] rs_p0, rs_nxt;
    logic signed [31:0] rt_p0, rt_nxt;
    logic [31:0]        hi_q, hi_nxt;
    logic [31:0]        lo_q, lo_nxt;
    logic [63:0]        res;
    logic               is_long_op;
    logic               div_by_zero;

    // {hi, lo} for the latched op; divide-by-zero yields a don't-care 0 that is never committed.
    function automatic logic [63:0] md_calc(input logic [2:0] op,
                                            input logic signed [31:0] a,
                                            input logic signed [31:0] b);
        logic signed [63:0] sprod;
        logic        [63:0] uprod;
        logic signed [32:0] sq, sr;
        logic        [31:0] uq, ur;
        sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod = {32'd0, a} * {32'd0, b};
        sq = '0;
        sr = '0;
        uq = '0;
        ur = '0;
        if (b != 32'sd0) begin
            // 33-bit signed divide keeps 0x80000000 / -1 from overflowing; low bits wrap to 0x80000000.
            sq = $signed({a[31], a}) / $signed({b[31], b});
            sr = $signed({a[31], a}) % $signed({b[31], b});
            uq = unsigned'(a) / unsigned'(b);
            ur = unsigned'(a) % unsigned'(b);
        end
        case (op)
            OP_MULT:  md_calc = sprod;
            OP_MULTU: md_calc = uprod;
            OP_DIV:   md_calc = {sr[31:0], sq[31:0]};
            OP_DIVU:  md_calc = {ur, uq};
            default:  md_calc = '0;
        endcase
    endfunction

    assign is_long_op  = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU) ||
                         (md.md_op == OP_DIV)  || (md.md_op == OP_DIVU);
    assign div_by_zero = ((op_p0 == OP_DIV) || (op_p0 == OP_DIVU)) && (rt_p0 == 32'sd0);
    assign res         = md_calc(op_p0, rs_p0, rt_p0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_p0;
        rs_nxt    = rs_p0;
        rt_nxt    = rt_p0;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        case (state)
            IDLE: begin
                if (md.start) begin
                    if (is_long_op) begin
                        op_nxt    = md.md_op;
                        rs_nxt    = $signed(md.rs_val);
                        rt_nxt    = $signed(md.rt_val);
                        cnt_nxt   = ((md.md_op == OP_DIV) || (md.md_op == OP_DIVU)) ? DIV_CNT : MULT_CNT;
                        state_nxt = BUSY;
                    end else if (md.md_op == OP_MTHI) begin
                        hi_nxt = md.rs_val;
                    end else if (md.md_op == OP_MTLO) begin
                        lo_nxt = md.rs_val;
                    end
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = IDLE;
                    if (!div_by_zero) begin
                        hi_nxt = res[63:32];
                        lo_nxt = res[31:0];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: issue-edge latches and architectural HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_p0 <= '0;
            rs_p0 <= '0;
            rt_p0 <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_p0 <= op_nxt;
            rs_p0 <= rs_nxt;
            rt_p0 <= rt_nxt;
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
        end
    end

    assign md.busy     = (state == BUSY);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.md_stall = md.md_use_D & ((state == BUSY) | (md.start & is_long_op));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed plus randomized bench for mdu_ctrl against an arithmetic model of HI/LO.
module tb_mdu_ctrl;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    mdu_if ifc();

    mdu_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (ifc)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The hazard unit never issues into a busy controller; guard the stimulus.
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(ifc.busy && ifc.start)) else begin
                n_bad++;
                $error("FAIL start_while_busy: observed 1 expected 0");
            end
        end
    end

    // HI/LO as the instruction set defines them, computed with plain integer arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int                sa, sb;
        longint            sp;
        longint unsigned   ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd1: begin
                sp = longint'(sa) * longint'(sb);
                exp_hi = sp[63:32];
                exp_lo = sp[31:0];
            end
            3'd2: begin
                ua = {32'd0, a};
                ub = {32'd0, b};
                up = ua * ub;
                exp_hi = up[63:32];
                exp_lo = up[31:0];
            end
            3'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    exp_lo = 32'h8000_0000;
                    exp_hi = 32'h0;
                end else begin
                    exp_lo = sa / sb;
                    exp_hi = sa % sb;
                end
            end
            3'd4: if (b != 0) begin
                exp_lo = a / b;
                exp_hi = a % b;
            end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op at the current cycle; returns positioned in the first cycle it may issue again.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d);
        bit long_op;
        int lat;
        long_op = (op >= 3'd1 && op <= 3'd4);
        lat     = (op == 3'd3 || op == 3'd4) ? DIV_LAT : MULT_LAT;
        ifc.start    = 1'b1;
        ifc.md_op    = op;
        ifc.rs_val   = a;
        ifc.rt_val   = b;
        ifc.md_use_D = use_d;
        #1;
        chk("stall_issue", 32'(ifc.md_stall), 32'(use_d && long_op));
        @(posedge clk); #1;
        ifc.start  = 1'b0;
        ifc.md_op  = 3'(op + 3'd3);
        ifc.rs_val = $urandom;
        ifc.rt_val = $urandom;
        if (long_op) begin
            for (int i = 1; i <= lat; i++) begin
                chk("busy_run", 32'(ifc.busy), 32'd1);
                chk("stall_run", 32'(ifc.md_stall), 32'(use_d));
                if (i == 1) chk("hi_hold", ifc.hi, exp_hi);
                @(posedge clk); #1;
            end
        end
        model(op, a, b);
        chk("busy_done", 32'(ifc.busy), 32'd0);
        chk("stall_done", 32'(ifc.md_stall), 32'd0);
        chk("hi", ifc.hi, exp_hi);
        chk("lo", ifc.lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        ifc.start    = 1'b0;
        ifc.md_op    = 3'd0;
        ifc.rs_val   = '0;
        ifc.rt_val   = '0;
        ifc.md_use_D = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_hi", ifc.hi, 32'd0);
        chk("rst_lo", ifc.lo, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_hi_const", ifc.hi, 32'hFFFF_FFFF);
        chk("mult_lo_const", ifc.lo, 32'hFFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_hi_const", ifc.hi, 32'h0000_0001);
        chk("multu_lo_const", ifc.lo, 32'hFFFF_FFFE);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_lo_const", ifc.lo, 32'hFFFF_FFFD);
        chk("div_hi_const", ifc.hi, 32'hFFFF_FFFF);
        run_op(3'd4, 32'd7, 32'd0, 1'b0);
        chk("divz_hi_const", ifc.hi, 32'hFFFF_FFFF);
        chk("divz_lo_const", ifc.lo, 32'hFFFF_FFFD);

        run_op(3'd5, 32'h1234, 32'd0, 1'b1);
        run_op(3'd6, 32'h5678, 32'd0, 1'b1);
        chk("mthi_const", ifc.hi, 32'h1234);
        chk("mtlo_const", ifc.lo, 32'h5678);
        run_op(3'd0, 32'hDEAD_BEEF, 32'd1, 1'b1);
        run_op(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0);

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("ovf_lo_const", ifc.lo, 32'h8000_0000);
        chk("ovf_hi_const", ifc.hi, 32'h0);
        run_op(3'd3, 32'd100, 32'hFFFF_FFF9, 1'b0);
        run_op(3'd1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);

        // Reset in the 4th busy cycle of a divide discards it and clears HI/LO.
        ifc.start    = 1'b1;
        ifc.md_op    = 3'd3;
        ifc.rs_val   = 32'd1000;
        ifc.rt_val   = 32'd7;
        ifc.md_use_D = 1'b0;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", 32'(ifc.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        chk("mid_rst_busy", 32'(ifc.busy), 32'd0);
        chk("mid_rst_hi", ifc.hi, 32'd0);
        chk("mid_rst_lo", ifc.lo, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_hi", ifc.hi, 32'd0);
        run_op(3'd1, 32'd12345, 32'hFFFF_FF00, 1'b0);

        for (int n = 0; n < 60; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                3: ra = -32'($urandom_range(1, 99));
                default: ;
            endcase
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
